// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: shared ALU command and CSR index types, CSR addresses and write masks
package csr_unit_pkg;
  typedef enum logic [3:0] {
    c_ADD, c_SUB, c_AND, c_OR, c_XOR, c_SLL, c_SRL, c_SRA, c_SLT, c_SLTU,
    c_CSRRW, c_CSRRS, c_CSRRC
  } alu_commands_t;
  typedef enum logic [4:0] {
    CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
    CSR_MTVAL, CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID,
    CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_FLUSH, CSR_FLUSHH,
    CSR_WAIT, CSR_WAITH, CSR_DECODE, CSR_DECODEH, CSR_NONE
  } csr_t;
  localparam int CSR_NUM = 24;
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_FLUSH     = 12'hC03;
  localparam logic [11:0] ADDR_FLUSHH    = 12'hC83;
  localparam logic [11:0] ADDR_WAIT      = 12'hC04;
  localparam logic [11:0] ADDR_WAITH     = 12'hC84;
  localparam logic [11:0] ADDR_DECODE    = 12'hC05;
  localparam logic [11:0] ADDR_DECODEH   = 12'hC85;
  localparam logic [31:0] MISA_VAL = 32'h4000_1100;
  localparam logic [31:0] CSR_WMASK [CSR_NUM] = '{
    CSR_MSTATUS:  32'h0000_7188,
    CSR_MIE:      32'h0000_0888,
    CSR_MTVEC:    32'hFFFF_FFFC,
    CSR_MSCRATCH: 32'hFFFF_FFFF,
    CSR_MEPC:     32'hFFFF_FFFE,
    CSR_MCAUSE:   32'hFFFF_FFFF,
    CSR_MTVAL:    32'hFFFF_FFFF,
    default:      32'h0000_0000
  };
  function automatic csr_t csr_decode(input logic [11:0] a);
    case (a)
      ADDR_MSTATUS:   return CSR_MSTATUS;
      ADDR_MISA:      return CSR_MISA;
      ADDR_MIE:       return CSR_MIE;
      ADDR_MTVEC:     return CSR_MTVEC;
      ADDR_MSCRATCH:  return CSR_MSCRATCH;
      ADDR_MEPC:      return CSR_MEPC;
      ADDR_MCAUSE:    return CSR_MCAUSE;
      ADDR_MTVAL:     return CSR_MTVAL;
      ADDR_MIP:       return CSR_MIP;
      ADDR_MVENDORID: return CSR_MVENDORID;
      ADDR_MARCHID:   return CSR_MARCHID;
      ADDR_MIMPID:    return CSR_MIMPID;
      ADDR_MHARTID:   return CSR_MHARTID;
      ADDR_CYCLE:     return CSR_CYCLE;
      ADDR_CYCLEH:    return CSR_CYCLEH;
      ADDR_INSTRET:   return CSR_INSTRET;
      ADDR_INSTRETH:  return CSR_INSTRETH;
      ADDR_FLUSH:     return CSR_FLUSH;
      ADDR_FLUSHH:    return CSR_FLUSHH;
      ADDR_WAIT:      return CSR_WAIT;
      ADDR_WAITH:     return CSR_WAITH;
      ADDR_DECODE:    return CSR_DECODE;
      ADDR_DECODEH:   return CSR_DECODEH;
      default:        return CSR_NONE;
    endcase
  endfunction
endpackage

// File: rtl/csr_unit_perf_counter.sv
// csr_unit_perf_counter: 64-bit wrapping event counter with enable
module csr_unit_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= en ? q + 64'd1 : q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with masked read-modify-write, trap/mret state and performance counters
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          CSR_ADDR_W = 12,
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [31:0] MTVEC_RST  = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  alu_commands_t         req_cmd,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_illegal,
  input  logic                  trap_valid,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [XLEN-1:0]       trap_tval,
  input  logic                  mret_valid,
  input  logic                  ev_commit,
  input  logic                  ev_flush,
  input  logic                  ev_wait,
  input  logic                  ev_decode,
  output logic [XLEN-1:0]       mtvec_o,
  output logic [XLEN-1:0]       mepc_o,
  output logic                  mie_global_o
);
  csr_t idx;
  logic is_csr, wr_try, illegal, wr_en;
  logic [CSR_NUM-1:0] wsel;
  logic [XLEN-1:0] old, nv, wval, mask, mstatus_d;
  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [63:0] cyc_q, ins_q, fls_q, wai_q, dec_q;
  csr_unit_perf_counter u_cycle   (.clk(clk), .rst_n(rst_n), .en(1'b1),      .q(cyc_q));
  csr_unit_perf_counter u_instret (.clk(clk), .rst_n(rst_n), .en(ev_commit), .q(ins_q));
  csr_unit_perf_counter u_flush   (.clk(clk), .rst_n(rst_n), .en(ev_flush),  .q(fls_q));
  csr_unit_perf_counter u_wait    (.clk(clk), .rst_n(rst_n), .en(ev_wait),   .q(wai_q));
  csr_unit_perf_counter u_decode  (.clk(clk), .rst_n(rst_n), .en(ev_decode), .q(dec_q));
  assign idx     = csr_decode(req_addr);
  assign is_csr  = req_cmd inside {c_CSRRW, c_CSRRS, c_CSRRC};
  assign wr_try  = req_cmd == c_CSRRW || req_wdata != '0;
  assign illegal = idx == CSR_NONE || !is_csr || (req_addr[11:10] == 2'b11 && wr_try);
  assign wr_en   = req_valid && !illegal && wr_try;
  assign wsel    = CSR_NUM'(wr_en) << idx;
  assign mask    = CSR_WMASK[idx];
  assign nv      = req_cmd == c_CSRRW ? req_wdata : req_cmd == c_CSRRS ? old | req_wdata : old & ~req_wdata;
  assign wval    = (old & ~mask) | (nv & mask);
  always_comb
    case (idx)
      CSR_MSTATUS:  old = mstatus_q;
      CSR_MISA:     old = MISA_VAL;
      CSR_MIE:      old = mie_q;
      CSR_MTVEC:    old = mtvec_q;
      CSR_MSCRATCH: old = mscratch_q;
      CSR_MEPC:     old = mepc_q;
      CSR_MCAUSE:   old = mcause_q;
      CSR_MTVAL:    old = mtval_q;
      CSR_MIP:      old = mip_q;
      CSR_MHARTID:  old = HART_ID;
      CSR_CYCLE:    old = cyc_q[31:0];
      CSR_CYCLEH:   old = cyc_q[63:32];
      CSR_INSTRET:  old = ins_q[31:0];
      CSR_INSTRETH: old = ins_q[63:32];
      CSR_FLUSH:    old = fls_q[31:0];
      CSR_FLUSHH:   old = fls_q[63:32];
      CSR_WAIT:     old = wai_q[31:0];
      CSR_WAITH:    old = wai_q[63:32];
      CSR_DECODE:   old = dec_q[31:0];
      CSR_DECODEH:  old = dec_q[63:32];
      default:      old = '0;
    endcase
  // trap: MPIE <= MIE, MIE <= 0; mret: MIE <= MPIE, MPIE <= 1; both take precedence over a CSR write
  assign mstatus_d = trap_valid ? {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]}
                   : mret_valid ? {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]}
                   : wsel[CSR_MSTATUS] ? wval : mstatus_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_rd      <= '0;
      resp_illegal <= 1'b0;
      mstatus_q    <= '0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RST;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mip_q        <= '0;
    end else begin
      resp_valid   <= req_valid;
      resp_rdata   <= req_valid && !illegal ? old : '0;
      resp_rd      <= req_rd;
      resp_illegal <= req_valid && illegal;
      mstatus_q    <= mstatus_d;
      mie_q        <= wsel[CSR_MIE] ? wval : mie_q;
      mtvec_q      <= wsel[CSR_MTVEC] ? wval : mtvec_q;
      mscratch_q   <= wsel[CSR_MSCRATCH] ? wval : mscratch_q;
      mepc_q       <= trap_valid ? trap_pc & ~32'h1 : wsel[CSR_MEPC] ? wval : mepc_q;
      mcause_q     <= trap_valid ? trap_cause : wsel[CSR_MCAUSE] ? wval : mcause_q;
      mtval_q      <= trap_valid ? trap_tval : wsel[CSR_MTVAL] ? wval : mtval_q;
      mip_q        <= wsel[CSR_MIP] ? wval : mip_q;
    end
  assign mtvec_o      = mtvec_q;
  assign mepc_o       = mepc_q;
  assign mie_global_o = mstatus_q[3];
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and performance-counter block of the RV32 core; the consumer of the CSR command class (c_CSRRW/c_CSRRS/c_CSRRC) issued by the ALU-4 slot. It holds the 23 architectural and performance CSRs, applies per-register write masks, answers read-modify-write requests with a single registered response, and updates trap state (mepc, mcause, mstatus) on trap entry and mret. Trap-vector and interrupt-enable state are exported to fetch and control.

## Interface
- XLEN, 32, register width; only 32 is supported.
- CSR_ADDR_W, 12, CSR address width.
- HART_ID, 0, value returned by mhartid.
- MTVEC_RST, 32'h1000_0000, reset value of mtvec (= IF_BASE_ADDR).

- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CSR command present this cycle.
- req_cmd  in  alu_commands_t  c_CSRRW, c_CSRRS or c_CSRRC; any other value is treated as illegal.
- req_addr  in  12  CSR address.
- req_wdata  in  32  rs1 value or zero-extended immediate.
- req_rd  in  5  destination register tag, echoed.
- resp_valid  out  1  response valid, one cycle after req_valid.
- resp_rdata  out  32  old CSR value; 0 when illegal.
- resp_rd  out  5  echoed tag.
- resp_illegal  out  1  illegal access.
- trap_valid  in  1  trap entry.
- trap_pc  in  32  faulting PC.
- trap_cause  in  32  cause code.
- trap_tval  in  32  mtval value.
- mret_valid  in  1  mret retire.
- ev_commit, ev_flush, ev_wait, ev_decode  in  1 each  performance events, one per cycle max.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mie_global_o  out  1  mstatus.MIE.

## Operation
- Address map: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, flush 0xC03/0xC83, wait 0xC04/0xC84, decode 0xC05/0xC85.
- New value: RW = wdata; RS = old | wdata; RC = old & ~wdata. Stored = (old & ~WMASK) | (new & WMASK), using the package CSR_WMASK entry for the decoded csr_t index.
- Illegal: unmapped address, non-CSR command, or a write attempt to a read-only address (addr[11:10] == 2'b11). A write attempt is RW always, or RS/RC with wdata != 0. Illegal requests write nothing.
- Constants: misa 0x4000_1100 (RV32IM), vendor/arch/impl ID 0, mhartid HART_ID.
- Counters: 64-bit; cycle increments every cycle; the others increment on their event. All wrap from 2^64-1 to 0 and are read-only through the CSR port.
- Trap entry: mepc <= trap_pc & ~1, mcause <= trap_cause, mtval <= trap_tval, MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Priority in a single cycle: trap > mret > CSR write. A CSR write that loses to a trap or mret is dropped for the affected register; resp_rdata still returns the pre-edge value.

## Timing
- Reset values: all CSRs 0 except mtvec = MTVEC_RST; counters 0; resp_valid, resp_rdata, resp_rd and resp_illegal are 0.
- Latency 1: a request at edge N produces a response after edge N; the CSR update is visible to a request at edge N+1 (back-to-back requests are fully supported).
- No backpressure; a request is accepted every cycle.
- mtvec_o, mepc_o and mie_global_o come directly from registers.
- Reset asserted mid-operation clears everything asynchronously; any pending response is lost.

## Structure
- Shared package: csr_t, alu_commands_t, CSR_WMASK and the CSR address localparams (added to the CSR Addresses section).
- Sub-module perf_counter: 64-bit counter with enable; instantiated five times.

## Test plan
- Reset: mtvec read (CSRRS, wdata 0) returns 0x1000_0000; mstatus read returns 0; misa returns 0x4000_1100.
- Write mask: CSRRW mstatus 0xFFFF_FFFF then read returns 0x0000_7188; CSRRC mstatus 0x8 then read returns 0x0000_7180.
- Read-only: CSRRW cycle 0x5 returns resp_illegal = 1 and rdata 0; CSRRS mhartid with wdata 0 returns resp_illegal = 0 and rdata HART_ID.
- Trap then mret: with MIE = 1, trap_pc 0x1000_0043 and cause 0xB give mepc 0x1000_0042, mcause 0xB, MIE 0, MPIE 1; mret gives MIE 1.
- Conflict: CSRRW mepc 0x1234 issued in the same cycle as a trap with trap_pc 0x1000_0010 leaves mepc = 0x1000_0010 and returns the old mepc.
- Counter wrap: force cycle to 0xFFFF_FFFF_FFFF_FFFF; the next read returns cycle 0 and cycleh 0. 1000 ev_commit pulses give instret 1000.
